// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared types and constants for the framebuffer burst arbiter
package fb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

    // Side that owned the most recently completed burst.
    typedef enum logic {
        LG_WRITE = 1'b0,
        LG_READ  = 1'b1
    } last_grant_e;

endpackage

// File: rtl/fb_addr_ctr.sv
// rtl/fb_addr_ctr.sv - per-side frame word address with wrap and frame-done flag
module fb_addr_ctr
    import fb_arb_pkg::*;
#(
    parameter int FRAME_WORDS = 307200,
    parameter int ADDR_W      = 19
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            done_q <= DEASSERT_H;
        end else begin
            addr_q <= addr_d;
            done_q <= done_d;
        end
    end

    // The wrap beat is always the last beat of a burst, so clear and set never collide.
    always_comb begin
        addr_d = addr_q;
        done_d = done_q;
        if (clr_i) begin
            done_d = DEASSERT_H;
        end
        if (inc_i) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
                done_d = ASSERT_H;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    assign addr_o = addr_q;
    assign done_o = done_q;

endmodule

// File: rtl/fb_burst_arb.sv
// rtl/fb_burst_arb.sv - ping-pong framebuffer burst arbiter between camera writes and display reads
module fb_burst_arb
    import fb_arb_pkg::*;
#(
    parameter int BURST_SIZE  = 8,
    parameter int FRAME_WORDS = 307200,
    parameter int ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic              avl_ready,
    output logic              wr_grant,
    output logic              rd_grant,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_buf,
    output logic              rd_buf,
    output logic              swap,
    output logic [31:0]       frame_num
);

    localparam int CNT_W = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_SIZE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    last_grant_e       last_grant_q, last_grant_d;
    logic              wr_grant_q, wr_grant_d;
    logic              rd_grant_q, rd_grant_d;
    logic              wr_buf_q, wr_buf_d;
    logic              rd_buf_q, rd_buf_d;
    logic              swap_q, swap_d;
    logic [31:0]       frame_num_q, frame_num_d;

    logic wr_done, rd_done;
    logic wr_ok, rd_ok;
    logic wr_beat, rd_beat;

    assign wr_beat = wr_grant_q & avl_ready;
    assign rd_beat = rd_grant_q & avl_ready;
    assign wr_ok   = wr_req & ~wr_done;
    assign rd_ok   = rd_req & ~rd_done;
    assign swap_d  = wr_done & rd_done;

    fb_addr_ctr #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_wr_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (wr_beat),
        .clr_i  (swap_d),
        .addr_o (wr_addr),
        .done_o (wr_done)
    );

    fb_addr_ctr #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_rd_ctr (
        .clk_i  (clk),
        .rst_ni (reset),
        .inc_i  (rd_beat),
        .clr_i  (swap_d),
        .addr_o (rd_addr),
        .done_o (rd_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            last_grant_q <= LG_READ;
            wr_grant_q   <= DEASSERT_H;
            rd_grant_q   <= DEASSERT_H;
            wr_buf_q     <= DEASSERT_H;
            rd_buf_q     <= ASSERT_H;
            swap_q       <= DEASSERT_H;
            frame_num_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            wr_grant_q   <= wr_grant_d;
            rd_grant_q   <= rd_grant_d;
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
            swap_q       <= swap_d;
            frame_num_q  <= frame_num_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        frame_num_d  = frame_num_q;

        unique case (state_q)
            S_IDLE: begin
                // Urgent reads pre-empt round-robin; ties go to the side that did not go last.
                if (rd_ok && rd_urgent) begin
                    state_d = S_RD;
                end else if (wr_ok && rd_ok) begin
                    state_d = (last_grant_q == LG_READ) ? S_WR : S_RD;
                end else if (wr_ok) begin
                    state_d = S_WR;
                end else if (rd_ok) begin
                    state_d = S_RD;
                end
            end
            S_WR, S_RD: begin
                if (wr_beat || rd_beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d   = '0;
                        state_d      = S_GAP;
                        last_grant_d = (state_q == S_WR) ? LG_WRITE : LG_READ;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (swap_d) begin
            wr_buf_d    = ~wr_buf_q;
            rd_buf_d    = ~rd_buf_q;
            frame_num_d = frame_num_q + 32'd1;
        end

        wr_grant_d = (state_d == S_WR);
        rd_grant_d = (state_d == S_RD);
    end

    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;
    assign wr_buf    = wr_buf_q;
    assign rd_buf    = rd_buf_q;
    assign swap      = swap_q;
    assign frame_num = frame_num_q;

endmodule

// File: doc/fb_burst_arb.md
# fb_burst_arb

Burst-granular arbiter that shares the single framebuffer memory port between the camera write path and the display read path. It runs a ping-pong buffer pair: the writer fills one buffer while the reader drains the other, and the roles swap only when both have finished a full frame. It sits between the camera/ADV FIFOs and the memory controller and replaces per-side burst toggling with one scheduler.

## Interface
- BURST_SIZE, 8: words per burst; FRAME_WORDS must be a multiple of it
- FRAME_WORDS, 307200: words per frame (640x480)
- ADDR_W, 19: address width; 2^ADDR_W >= FRAME_WORDS

- clk  in  1  memory-side clock
- reset  in  1  asynchronous, active-low
- wr_req  in  1  camera FIFO holds >= BURST_SIZE words
- rd_req  in  1  ADV FIFO has room for >= BURST_SIZE words
- rd_urgent  in  1  ADV FIFO is below its low watermark
- avl_ready  in  1  memory accepts one beat this cycle
- wr_grant  out  1  write burst active; one beat per cycle with avl_ready
- rd_grant  out  1  read burst active; one beat per cycle with avl_ready
- wr_addr  out  ADDR_W  word address of the current write beat
- rd_addr  out  ADDR_W  word address of the current read beat
- wr_buf  out  1  buffer being written
- rd_buf  out  1  buffer being read; always ~wr_buf
- swap  out  1  one-cycle pulse when the buffers exchange
- frame_num  out  32  count of completed swaps

## Operation
- States: S_IDLE, S_WR, S_RD, S_GAP. All outputs are registered.
- Per-side eligibility: wr_ok = wr_req & ~wr_done; rd_ok = rd_req & ~rd_done.
- Decisions in S_IDLE:
  - rd_ok & rd_urgent -> S_RD.
  - Otherwise, if both are eligible, round-robin against last_grant; the side that did not go last wins.
  - Otherwise the single eligible side wins.
  - If neither is eligible, stay in S_IDLE.
- S_WR / S_RD:
  - A beat is avl_ready & grant.
  - Each beat increments beat_cnt and the matching address.
  - On the beat with beat_cnt == BURST_SIZE-1 -> S_GAP and update last_grant.
  - Once granted, a burst always completes; wr_req, rd_req and rd_urgent are ignored mid-burst.
- S_GAP: one turnaround cycle, then -> S_IDLE.
- Address wrap:
  - A beat at address FRAME_WORDS-1 sets the address to 0 and sets the side's done flag (wr_done or rd_done).
  - A side whose done flag is set is never granted.
- Swap:
  - Triggered in any cycle where wr_done & rd_done are both set.
  - Effects: toggle wr_buf/rd_buf, clear both done flags, pulse swap, increment frame_num.
- Simultaneous events: if the final beat that sets a done flag lands in the same cycle the other flag is already set, the swap happens on the next cycle. There is no same-cycle set-and-swap.
- frame_num wraps modulo 2^32.

## Timing
- Reset values: state S_IDLE, wr_grant=0, rd_grant=0, wr_addr=0, rd_addr=0, wr_buf=0, rd_buf=1, swap=0, frame_num=0, beat_cnt=0, done flags=0, last_grant=read (the first tie goes to write).
- Request to grant latency: request sampled in S_IDLE, grant high the next cycle.
- Grant falls the cycle after the final beat.
- Minimum back-to-back burst overhead is 2 idle cycles (S_GAP + S_IDLE).
- With avl_ready held high, a burst lasts exactly BURST_SIZE cycles.
- Reset asserted mid-burst: every output returns to its reset value immediately (asynchronous). The partial burst is abandoned and addresses restart at 0.
- swap is high for exactly one cycle per frame.

## Structure
- Package fb_arb_pkg: state enum, ASSERT_H/DEASSERT_H constants, and the READ/WRITE encoding for last_grant.
- Sub-module fb_addr_ctr, instantiated twice (write, read). Parameters FRAME_WORDS and ADDR_W. It provides the address register, wrap logic, done flag, and a clear input driven by swap.
- The top level holds the FSM, beat counter, arbitration and buffer select.

## Test plan
(All cases use BURST_SIZE=4, FRAME_WORDS=16, ADDR_W=4.)
- **Reset:** reset low, then high -> wr_buf=0, rd_buf=1, both grants 0, addresses 0, frame_num=0.
- **Single writer:** wr_req=1, rd_req=0, avl_ready=1 -> wr_grant high for 4 cycles, wr_addr 0..3, then 2 idle cycles, then the next burst at addr 4.
- **Tie:** wr_req=rd_req=1 continuously -> grants alternate W,R,W,R. A raised rd_urgent forces R next even when W is due.
- **Stall:** avl_ready toggling 1,0,1,0 -> the burst takes 8 cycles and addresses advance only on ready cycles.
- **Frame completion:** writer finishes 16 words while the reader has done 8 -> no further wr_grant. When the reader reaches 16: one swap pulse, wr_buf=1, rd_buf=0, frame_num=1, both addresses 0.
- **Reset mid-burst:** reset asserted on beat 2 of a read -> rd_grant=0 immediately. After release, the first read is at rd_addr=0.
